// File: rtl/pong_ball_engine.sv
// Pong game-state engine: per-frame ball motion, wall/paddle bounces, scoring, game sequencing.
// Optional PONG_SPEEDUP_EN: each paddle hit speeds the ball up by 1, capped at MAX_SPEED.
module pong_ball_engine #(
  parameter int H_VIDEO       = 640,
  parameter int V_VIDEO       = 480,
  parameter int SQUARE_WIDTH  = 16,
  parameter int PADDLE_WIDTH  = 12,
  parameter int PADDLE_HEIGHT = 96,
  parameter int PADDLE1_X     = 32,
  parameter int PADDLE2_X     = 596,
  parameter int BALL_SPEED    = 4,
  parameter int MAX_SPEED     = 8,
  parameter int SERVE_FRAMES  = 60,
  parameter int WIN_SCORE     = 9
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic [9:0] paddle1_ypos,
  input  logic [9:0] paddle2_ypos,
  output logic [9:0] square_xpos,
  output logic [9:0] square_ypos,
  output logic       sq_shown,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       game_over,
  output logic       game_startup
);

  localparam int          CNT_W       = $clog2(SERVE_FRAMES + 1);
  localparam logic [10:0] X_MAX       = 11'(H_VIDEO - SQUARE_WIDTH);
  localparam logic [10:0] Y_MAX       = 11'(V_VIDEO - SQUARE_WIDTH);
  localparam logic [9:0]  X_CENTRE    = 10'((H_VIDEO - SQUARE_WIDTH) / 2);
  localparam logic [9:0]  Y_CENTRE    = 10'((V_VIDEO - SQUARE_WIDTH) / 2);
  localparam logic [10:0] P1_EDGE     = 11'(PADDLE1_X + PADDLE_WIDTH);
  localparam logic [10:0] P2_EDGE     = 11'(PADDLE2_X - SQUARE_WIDTH);
  localparam logic [10:0] SIDE        = 11'(SQUARE_WIDTH);
  localparam logic [10:0] PAD_H       = 11'(PADDLE_HEIGHT);
  localparam logic [3:0]  SPEED_CAP   = 4'(MAX_SPEED);
  localparam logic [3:0]  START_SPEED = (4'(BALL_SPEED) > SPEED_CAP) ? SPEED_CAP : 4'(BALL_SPEED);
  localparam logic [3:0]  WIN         = 4'(WIN_SCORE);
  localparam logic [CNT_W-1:0] LAST_SERVE = CNT_W'(SERVE_FRAMES - 1);

  typedef enum logic [1:0] {STARTUP, SERVE, PLAY, GAME_OVER} state_t;

  state_t           state, state_nxt;
  logic [9:0]       x, x_nxt, y, y_nxt, y_play;
  logic             dx, dx_nxt, dy, dy_nxt, dy_play;
  logic [3:0]       speed;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       s1, s1_nxt, s2, s2_nxt, s1_inc, s2_inc;
  logic             shown, shown_nxt, over, over_nxt, startup, startup_nxt;
  logic             btn_q, btn_prev, press;
  logic [10:0]      x_w, y_w, s_w, p1_w, p2_w;
  logic             overlap1, overlap2, hit_l, hit_r, miss_l, miss_r;

  assign press  = btn_q & ~btn_prev;
  assign s1_inc = s1 + 4'd1;
  assign s2_inc = s2 + 4'd1;

  // dx=1 means moving right, dy=1 means moving down; all maths in 11 bits so nothing wraps
  assign x_w  = {1'b0, x};
  assign y_w  = {1'b0, y};
  assign s_w  = {7'b0, speed};
  assign p1_w = {1'b0, paddle1_ypos};
  assign p2_w = {1'b0, paddle2_ypos};

  assign overlap1 = (y_w + SIDE > p1_w) && (y_w < p1_w + PAD_H);
  assign overlap2 = (y_w + SIDE > p2_w) && (y_w < p2_w + PAD_H);
  assign hit_l    = !dx && (x_w >= P1_EDGE) && (x_w - s_w <= P1_EDGE) && overlap1;
  assign hit_r    =  dx && (x_w <= P2_EDGE) && (x_w + s_w >= P2_EDGE) && overlap2;
  assign miss_l   = !dx && !hit_l && (x_w < s_w);
  assign miss_r   =  dx && !hit_r && (x_w + s_w > X_MAX);

  always_comb begin
    y_play  = y;
    dy_play = dy;
    if (!dy) begin
      if (y_w < s_w) begin
        y_play  = 10'd0;
        dy_play = 1'b1;
      end else begin
        y_play = 10'(y_w - s_w);
      end
    end else begin
      if (y_w + s_w > Y_MAX) begin
        y_play  = 10'(Y_MAX);
        dy_play = 1'b0;
      end else begin
        y_play = 10'(y_w + s_w);
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    x_nxt       = x;
    y_nxt       = y;
    dx_nxt      = dx;
    dy_nxt      = dy;
    cnt_nxt     = cnt;
    s1_nxt      = s1;
    s2_nxt      = s2;
    shown_nxt   = shown;
    over_nxt    = over;
    startup_nxt = startup;
    case (state)
      STARTUP: begin
        if (press) begin
          s1_nxt      = 4'd0;
          s2_nxt      = 4'd0;
          startup_nxt = 1'b0;
          x_nxt       = X_CENTRE;
          y_nxt       = Y_CENTRE;
          cnt_nxt     = '0;
          state_nxt   = SERVE;
        end
      end
      SERVE: begin
        x_nxt     = X_CENTRE;
        y_nxt     = Y_CENTRE;
        shown_nxt = 1'b0;
        if (frame_tick) begin
          if (cnt == LAST_SERVE) begin
            cnt_nxt   = '0;
            shown_nxt = 1'b1;
            state_nxt = PLAY;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      PLAY: begin
        if (frame_tick) begin
          y_nxt  = y_play;
          dy_nxt = dy_play;
          if (hit_l) begin
            x_nxt  = 10'(P1_EDGE);
            dx_nxt = 1'b1;
          end else if (hit_r) begin
            x_nxt  = 10'(P2_EDGE);
            dx_nxt = 1'b0;
          end else if (miss_l || miss_r) begin
            // Direction is kept so the next serve heads toward whoever conceded
            x_nxt     = X_CENTRE;
            y_nxt     = Y_CENTRE;
            shown_nxt = 1'b0;
            cnt_nxt   = '0;
            if (miss_l) s2_nxt = s2_inc;
            else        s1_nxt = s1_inc;
            if ((miss_l && s2_inc == WIN) || (miss_r && s1_inc == WIN)) begin
              over_nxt  = 1'b1;
              state_nxt = GAME_OVER;
            end else begin
              state_nxt = SERVE;
            end
          end else if (dx) begin
            x_nxt = 10'(x_w + s_w);
          end else begin
            x_nxt = 10'(x_w - s_w);
          end
        end
      end
      GAME_OVER: begin
        if (press) begin
          over_nxt    = 1'b0;
          startup_nxt = 1'b1;
          state_nxt   = STARTUP;
        end
      end
      default: state_nxt = STARTUP;
    endcase
  end

  always_ff @(posedge clk_0) begin
    if (!rst) begin
      state    <= STARTUP;
      x        <= X_CENTRE;
      y        <= Y_CENTRE;
      dx       <= 1'b1;
      dy       <= 1'b1;
      cnt      <= '0;
      s1       <= 4'd0;
      s2       <= 4'd0;
      shown    <= 1'b0;
      over     <= 1'b0;
      startup  <= 1'b1;
      btn_q    <= 1'b0;
      btn_prev <= 1'b0;
    end else begin
      state    <= state_nxt;
      x        <= x_nxt;
      y        <= y_nxt;
      dx       <= dx_nxt;
      dy       <= dy_nxt;
      cnt      <= cnt_nxt;
      s1       <= s1_nxt;
      s2       <= s2_nxt;
      shown    <= shown_nxt;
      over     <= over_nxt;
      startup  <= startup_nxt;
      btn_q    <= start_btn;
      btn_prev <= btn_q;
    end
  end

`ifdef PONG_SPEEDUP_EN
  logic [3:0] speed_nxt;

  // Speed falls back to the serve speed whenever a serve is pending
  always_comb begin
    speed_nxt = speed;
    if (state == SERVE || state_nxt == SERVE)
      speed_nxt = START_SPEED;
    else if (state == PLAY && frame_tick && (hit_l || hit_r) && speed < SPEED_CAP)
      speed_nxt = speed + 4'd1;
  end

  always_ff @(posedge clk_0) begin
    if (!rst) speed <= START_SPEED;
    else      speed <= speed_nxt;
  end
`else
  assign speed = START_SPEED;
`endif

  assign square_xpos  = x;
  assign square_ypos  = y;
  assign sq_shown     = shown;
  assign score_p1     = s1;
  assign score_p2     = s2;
  assign game_over    = over;
  assign game_startup = startup;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Directed self-checking bench for pong_ball_engine; honours PONG_SPEEDUP_EN for post-hit speeds.
module tb_pong_ball_engine;

  logic       clk_0 = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       start_btn;
  logic [9:0] paddle1_ypos;
  logic [9:0] paddle2_ypos;
  logic [9:0] square_xpos;
  logic [9:0] square_ypos;
  logic       sq_shown;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic       game_over;
  logic       game_startup;

  int assertCount = 0;
  int failCount   = 0;
  int guardCount;

  always #5 clk_0 = ~clk_0;

  pong_ball_engine dut (
    .clk_0        (clk_0),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .start_btn    (start_btn),
    .paddle1_ypos (paddle1_ypos),
    .paddle2_ypos (paddle2_ypos),
    .square_xpos  (square_xpos),
    .square_ypos  (square_ypos),
    .sq_shown     (sq_shown),
    .score_p1     (score_p1),
    .score_p2     (score_p2),
    .game_over    (game_over),
    .game_startup (game_startup)
  );

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // One clock cycle of stimulus, returning at the following falling edge
  task automatic applyStimulus(input logic tickIn, input logic btnIn);
    frame_tick = tickIn;
    start_btn  = btnIn;
    @(posedge clk_0);
    @(negedge clk_0);
  endtask

  task automatic frameTicks(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
    end
  endtask

  task automatic pressStart();
    repeat (3) applyStimulus(1'b0, 1'b1);
    repeat (2) applyStimulus(1'b0, 1'b0);
  endtask

  task automatic checkPos(input string tag, input int ex, input int ey);
    checkOutput({tag, "_x"}, 16'(square_xpos), 16'(ex));
    checkOutput({tag, "_y"}, 16'(square_ypos), 16'(ey));
  endtask

  task automatic checkResetState(input string tag);
    checkPos(tag, 312, 232);
    checkOutput({tag, "_shown"}, 16'(sq_shown), 16'd0);
    checkOutput({tag, "_startup"}, 16'(game_startup), 16'd1);
    checkOutput({tag, "_over"}, 16'(game_over), 16'd0);
    checkOutput({tag, "_p1"}, 16'(score_p1), 16'd0);
    checkOutput({tag, "_p2"}, 16'(score_p2), 16'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst          = 1'b0;
    frame_tick   = 1'b0;
    start_btn    = 1'b0;
    paddle1_ypos = 10'd0;
    paddle2_ypos = 10'd0;
    @(negedge clk_0);
    repeat (3) applyStimulus(1'b0, 1'b0);
    checkResetState("reset");
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0);

    // First serve heads right and down at speed 4
    pressStart();
    checkOutput("start_startup", 16'(game_startup), 16'd0);
    frameTicks(59);
    checkOutput("serve59_shown", 16'(sq_shown), 16'd0);
    frameTicks(1);
    checkOutput("serve60_shown", 16'(sq_shown), 16'd1);
    checkPos("serve60", 312, 232);
    frameTicks(1);
    checkPos("play1", 316, 236);
    frameTicks(57);
    checkPos("play58", 544, 464);
    frameTicks(1);
    checkPos("wall_clamp", 548, 464);
    frameTicks(1);
    checkPos("wall_up", 552, 460);
    frameTicks(18);
    checkPos("play78", 624, 388);
    checkOutput("play78_p1", 16'(score_p1), 16'd0);
    frameTicks(1);
    checkOutput("miss_r_p1", 16'(score_p1), 16'd1);
    checkOutput("miss_r_shown", 16'(sq_shown), 16'd0);
    checkOutput("miss_r_over", 16'(game_over), 16'd0);
    checkPos("miss_r", 312, 232);

    // Second serve keeps dx right, dy now up; rally off both paddles
    paddle1_ypos = 10'd300;
    frameTicks(60);
    checkOutput("serve2_shown", 16'(sq_shown), 16'd1);
    frameTicks(1);
    checkPos("serve2_play1", 316, 228);
    frameTicks(65);
    checkPos("pre_hit_r", 576, 28);
    frameTicks(1);
    checkPos("hit_r", 580, 32);
    frameTicks(1);
`ifdef PONG_SPEEDUP_EN
    checkPos("after_hit_r", 575, 37);
    frameTicks(106);
    checkOutput("pre_hit_l_x", 16'(square_xpos), 16'd45);
    frameTicks(1);
    checkPos("hit_l", 44, 359);
    frameTicks(1);
    checkPos("after_hit_l", 50, 353);
`else
    checkPos("after_hit_r", 576, 36);
    frameTicks(132);
    checkOutput("pre_hit_l_x", 16'(square_xpos), 16'd48);
    frameTicks(1);
    checkPos("hit_l", 44, 364);
    frameTicks(1);
    checkPos("after_hit_l", 48, 360);
`endif
    checkOutput("rally_p1", 16'(score_p1), 16'd1);

    // Paddles parked where they can never overlap the ball
    paddle1_ypos = 10'd1000;
    paddle2_ypos = 10'd1000;
    guardCount = 0;
    while (sq_shown && guardCount < 400) begin
      frameTicks(1);
      guardCount++;
    end
    checkOutput("rally_end_shown", 16'(sq_shown), 16'd0);
    checkOutput("rally_end_p1", 16'(score_p1), 16'd2);
    checkOutput("rally_end_p2", 16'(score_p2), 16'd0);

    for (int sc = 3; sc <= 9; sc++) begin
      frameTicks(60);
      frameTicks(79);
      checkOutput("serve_miss_p1", 16'(score_p1), 16'(sc));
      checkOutput("serve_miss_over", 16'(game_over), 16'(sc == 9));
      checkOutput("serve_miss_shown", 16'(sq_shown), 16'd0);
    end
    frameTicks(3);
    checkOutput("over_hold_p1", 16'(score_p1), 16'd9);
    checkOutput("over_hold_over", 16'(game_over), 16'd1);

    // Press with frame_tick held high: the press wins, ticks are ignored
    repeat (3) applyStimulus(1'b1, 1'b1);
    repeat (2) applyStimulus(1'b0, 1'b0);
    checkOutput("to_startup_startup", 16'(game_startup), 16'd1);
    checkOutput("to_startup_over", 16'(game_over), 16'd0);
    checkOutput("to_startup_p1", 16'(score_p1), 16'd9);
    pressStart();
    checkOutput("restart_p1", 16'(score_p1), 16'd0);
    checkOutput("restart_p2", 16'(score_p2), 16'd0);
    checkOutput("restart_startup", 16'(game_startup), 16'd0);

    frameTicks(63);
    checkOutput("midplay_x", 16'(square_xpos), 16'd324);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0);
    checkResetState("midreset");
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0);
    pressStart();
    frameTicks(61);
    checkPos("post_reset_play1", 316, 236);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/pong_ball_engine.md
# pong_ball_engine

Game-state engine that drives the sprite and status inputs of the Pong renderer. Once per video frame it advances the ball, bounces it off the top/bottom walls and both paddles, detects misses, keeps score, and sequences startup, serve, play and game-over. Paddle positions come from the paddle controllers. Its outputs feed the renderer directly and stay stable during active video.

## Interface
Parameters:
- H_VIDEO, 640, active width in pixels
- V_VIDEO, 480, active height in lines
- SQUARE_WIDTH, 16, ball side length
- PADDLE_WIDTH, 12, paddle thickness
- PADDLE_HEIGHT, 96, paddle height
- PADDLE1_X, 32, left paddle x (left edge)
- PADDLE2_X, 596, right paddle x (left edge)
- BALL_SPEED, 4, initial pixels per frame per axis
- MAX_SPEED, 8, speed cap (speed-up feature only)
- SERVE_FRAMES, 60, frames the ball stays hidden before a serve
- WIN_SCORE, 9, winning score (must be ≤ 15)

Ports:
- clk_0  in  1  25.175 MHz pixel clock
- rst  in  1  synchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per frame, issued in vertical blanking
- start_btn  in  1  start button, active-high level, already synchronised
- paddle1_ypos  in  10  left paddle top y
- paddle2_ypos  in  10  right paddle top y
- square_xpos  out  10  ball top-left x
- square_ypos  out  10  ball top-left y
- sq_shown  out  1  ball visible
- score_p1  out  4  left player score
- score_p2  out  4  right player score
- game_over  out  1  game-over screen active
- game_startup  out  1  startup screen active

## Operation
- FSM states: STARTUP, SERVE, PLAY, GAME_OVER. Reset enters STARTUP.
- Reset values: square_xpos=312, square_ypos=232 (centre), sq_shown=0, scores=0, game_over=0, game_startup=1. Direction is dx=+1 (right), dy=+1 (down); speed=BALL_SPEED; serve counter=0. Reset mid-game returns to these values on the next clock edge.
- start_btn is rising-edge detected internally by comparing against its value one cycle earlier. A held button counts as one press.
- STARTUP: a press clears both scores, sets game_startup=0 and enters SERVE.
- SERVE: ball is held at the centre, sq_shown=0, speed=BALL_SPEED. Each frame_tick increments the counter. On the tick that brings the counter to SERVE_FRAMES, clear the counter, set sq_shown=1 and enter PLAY. The ball does not move on that tick.
- PLAY (per frame_tick, s=speed):
  - Vertical, moving up: if y < s, then y=0 and dy=down; otherwise y-=s.
  - Vertical, moving down: if y+s > V_VIDEO-SQUARE_WIDTH (464), then y=464 and dy=up; otherwise y+=s.
  - Left paddle hit: moving left, x ≥ 44 (PADDLE1_X+PADDLE_WIDTH), x-s ≤ 44, and vertical overlap (y+16 > p1y and y < p1y+96). Result: x=44, dx=right.
  - Right paddle hit: moving right, x ≤ 580 (PADDLE2_X-SQUARE_WIDTH), x+s ≥ 580, and overlap with paddle 2. Result: x=580, dx=left.
  - Left miss: moving left, no hit, and x < s. score_p2 increments.
  - Right miss: moving right, no hit, and x+s > 624. score_p1 increments.
  - Otherwise x moves by s in the current dx.
  - Overlap uses the pre-update y. Vertical and horizontal updates apply on the same tick.
- After a score: if the new score equals WIN_SCORE, enter GAME_OVER (game_over=1, sq_shown=0). Otherwise enter SERVE with the ball at the centre. dx and dy are kept, so the next serve goes toward the player who conceded.
- GAME_OVER: scores are held. A press sets game_over=0, game_startup=1 and enters STARTUP.
- Arithmetic uses 11-bit intermediates so that x+s and y+s cannot wrap. Positions are clamped to [0, 624] × [0, 464].

## Timing
- All outputs are registered. Updates triggered by frame_tick appear one cycle after the tick, which is still inside blanking.
- A button press takes effect one cycle after the edge-detect register sees 0→1 (2 clk_0 after start_btn rises).
- If a press and frame_tick coincide in STARTUP or GAME_OVER, the press transition wins and the tick is ignored. The first SERVE tick is the next frame_tick.
- Outside frame_tick cycles and button transitions, all state holds.

## Configuration
- PONG_SPEEDUP_EN defined: each paddle hit increments speed by 1, saturating at MAX_SPEED. Speed returns to BALL_SPEED on entering SERVE.
- PONG_SPEEDUP_EN undefined: speed is constant at BALL_SPEED, MAX_SPEED is unused, and the speed register may be optimised to a constant.

## Test plan
- Reset → square_xpos=312, square_ypos=232, sq_shown=0, game_startup=1, game_over=0, scores 0/0.
- Press start, issue 60 frame_ticks → sq_shown=1 after tick 60, position still 312/232. Tick 61 → 316/236.
- Ball moving down at y=462, speed 4, tick → y=464, dy=up. Next tick → y=460.
- paddle1_ypos=200, ball at x=46, y=220, moving left → x=44, dx=right. With PONG_SPEEDUP_EN, the next tick moves x to 49.
- paddle2_ypos=0, ball moving right at x=622, y=300 → score_p1=1, SERVE, sq_shown=0, ball at 312/232. The next serve moves right.
- score_p1=8, then a right miss → score_p1=9, game_over=1, sq_shown=0. Press → STARTUP with game_startup=1. Press again → scores 0/0. Asserting rst mid-PLAY → all reset values on the next cycle.
